// File: rtl/debounce_edge.sv
// debounce_edge: two-flop synchronizer followed by a qualification FSM that
// turns a bouncy asynchronous input into a clean registered level, with
// one-cycle rise/fall pulses and a wrapping count of rising events.
module debounce_edge #(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0,
    parameter int   EVT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_in,
    input  logic             clr,
    output logic             q_clean,
    output logic             rise,
    output logic             fall,
    output logic [EVT_W-1:0] rise_count
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam bit                SINGLE   = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        L2H  = 2'd1,
        HIGH = 2'd2,
        H2L  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = RESET_LEVEL ? HIGH : LOW;

    logic             r_s1;
    logic             r_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise_evt;

    // Two-flop synchronizer; only r_s feeds the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= RESET_LEVEL;
            r_s  <= RESET_LEVEL;
        end else begin
            r_s1 <= d_in;
            r_s  <= r_s1;
        end
    end

    // A rise event happens on the edge where the FSM enters HIGH from the low side.
    always_comb begin
        w_rise_evt = 1'b0;
        if (r_state == LOW && r_s && SINGLE)
            w_rise_evt = 1'b1;
        else if (r_state == L2H && r_s && r_cnt == CNT_LAST)
            w_rise_evt = 1'b1;
    end

    // Qualification FSM with registered level and pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RESET_STATE;
            r_cnt   <= '0;
            q_clean <= RESET_LEVEL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (r_state)
                LOW: begin
                    if (r_s) begin
                        if (SINGLE) begin
                            r_state <= HIGH;
                            r_cnt   <= '0;
                            q_clean <= 1'b1;
                            rise    <= 1'b1;
                        end else begin
                            r_state <= L2H;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                L2H: begin
                    if (!r_s) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                        q_clean <= 1'b1;
                        rise    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!r_s) begin
                        if (SINGLE) begin
                            r_state <= LOW;
                            r_cnt   <= '0;
                            q_clean <= 1'b0;
                            fall    <= 1'b1;
                        end else begin
                            r_state <= H2L;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                H2L: begin
                    if (r_s) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        q_clean <= 1'b0;
                        fall    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= RESET_STATE;
                    r_cnt   <= '0;
                    q_clean <= RESET_LEVEL;
                end
            endcase
        end
    end

    // Rising-event counter; clear wins over a coincident rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rise_count <= '0;
        else if (clr)
            rise_count <= '0;
        else if (w_rise_evt)
            rise_count <= rise_count + EVT_W'(1);
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: three instances (default, EVT_W=2, STABLE_CYCLES=1)
// share one stimulus stream and are compared every cycle against a
// consecutive-mismatch reference model.
module tb_debounce_edge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_in;
    logic       clr;

    logic       q4, r4, f4;
    logic [7:0] c4;
    logic       qw, rw, fw;
    logic [1:0] cw;
    logic       q1, r1, f1;
    logic [7:0] c1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debounce_edge #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .EVT_W(8)) dut (
        .clk(clk), .reset(rst_n), .d_in(d_in), .clr(clr),
        .q_clean(q4), .rise(r4), .fall(f4), .rise_count(c4)
    );

    debounce_edge #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .EVT_W(2)) dut_w2 (
        .clk(clk), .reset(rst_n), .d_in(d_in), .clr(clr),
        .q_clean(qw), .rise(rw), .fall(fw), .rise_count(cw)
    );

    debounce_edge #(.STABLE_CYCLES(1), .RESET_LEVEL(1'b0), .EVT_W(8)) dut_s1 (
        .clk(clk), .reset(rst_n), .d_in(d_in), .clr(clr),
        .q_clean(q1), .rise(r1), .fall(f1), .rise_count(c1)
    );

    // Reference model: the level flips once the synchronized input has
    // disagreed with it for STABLE_CYCLES consecutive edges.
    int         stab [2] = '{4, 1};
    logic       ms1, ms;
    logic       mq [2];
    int         mrun [2];
    logic       mr [2];
    logic       mf [2];
    logic [7:0] mc [2];

    task automatic model_reset();
        ms1 = 1'b0;
        ms  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mq[i] = 1'b0; mrun[i] = 0; mr[i] = 1'b0; mf[i] = 1'b0; mc[i] = 8'd0;
        end
    endtask

    task automatic model_edge(input logic d, input logic c);
        for (int i = 0; i < 2; i++) begin
            mr[i] = 1'b0;
            mf[i] = 1'b0;
            mrun[i] = (ms != mq[i]) ? mrun[i] + 1 : 0;
            if (mrun[i] == stab[i]) begin
                mq[i]   = ~mq[i];
                mr[i]   = mq[i];
                mf[i]   = ~mq[i];
                mrun[i] = 0;
            end
            if (c)
                mc[i] = 8'd0;
            else if (mr[i])
                mc[i] = mc[i] + 8'd1;
        end
        ms  = ms1;
        ms1 = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("q_clean",      32'(q4), 32'(mq[0]));
        chk("rise",         32'(r4), 32'(mr[0]));
        chk("fall",         32'(f4), 32'(mf[0]));
        chk("rise_count",   32'(c4), 32'(mc[0]));
        chk("w2_q_clean",   32'(qw), 32'(mq[0]));
        chk("w2_rise_count",32'(cw), 32'(mc[0][1:0]));
        chk("s1_q_clean",   32'(q1), 32'(mq[1]));
        chk("s1_rise",      32'(r1), 32'(mr[1]));
        chk("s1_fall",      32'(f1), 32'(mf[1]));
        chk("s1_rise_count",32'(c1), 32'(mc[1]));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic tick(input logic d, input logic c);
        d_in = d;
        clr  = c;
        @(posedge clk);
        if (rst_n)
            model_edge(d, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input logic d, input int n);
        for (int k = 0; k < n; k++)
            tick(d, 1'b0);
    endtask

    logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        int   n_rise;
        int   n_fall;
        int   rise_at;
        logic seen;
        logic cur_d;
        int   run_left;

        rst_n = 1'b0;
        d_in  = 1'b0;
        clr   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        hold(1'b0, 3);

        // Clean step: rise on E5, fall on the 6th edge after release.
        hold(1'b1, 5);
        chk("step_q_before_E5", 32'(q4), 32'd0);
        tick(1'b1, 1'b0);
        chk("step_rise_E5", 32'(r4), 32'd1);
        chk("step_q_E5",    32'(q4), 32'd1);
        chk("step_cnt_E5",  32'(c4), 32'd1);
        tick(1'b1, 1'b0);
        chk("step_rise_E6", 32'(r4), 32'd0);
        hold(1'b0, 5);
        chk("step_no_fall_yet", 32'(f4), 32'd0);
        tick(1'b0, 1'b0);
        chk("step_fall", 32'(f4), 32'd1);
        chk("step_cnt_after_fall", 32'(c4), 32'd1);
        hold(1'b0, 3);

        // Glitch of 3 cycles is rejected.
        seen = 1'b0;
        for (int k = 0; k < 13; k++) begin
            tick(k < 3, 1'b0);
            seen = seen | r4 | q4;
        end
        chk("glitch_no_rise", 32'(seen), 32'd0);
        chk("glitch_cnt",     32'(c4),   32'd1);

        // Bounce then hold high: exactly one rise, on the 6th held edge.
        n_rise = 0; n_fall = 0; rise_at = -1;
        for (int k = 0; k < 10; k++) begin
            tick((k % 2) == 0, 1'b0);
            n_rise += int'(r4);
            n_fall += int'(f4);
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0);
            if (r4) rise_at = k;
            n_rise += int'(r4);
            n_fall += int'(f4);
        end
        chk("bounce_rises",   32'(n_rise),  32'd1);
        chk("bounce_falls",   32'(n_fall),  32'd0);
        chk("bounce_rise_at", 32'(rise_at), 32'd5);
        chk("bounce_cnt",     32'(c4),      32'd2);
        hold(1'b0, 8);

        // Wrap of the 2-bit counter.
        tick(1'b0, 1'b1);
        chk("wrap_clr", 32'(cw), 32'd0);
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 6);
            chk("wrap_cnt", 32'(cw), 32'(wrap_exp[i]));
            hold(1'b0, 6);
        end

        // Clear coincident with a rise drops the event but the pulse remains.
        tick(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            hold(1'b1, 6);
            hold(1'b0, 6);
        end
        chk("coll_pre_cnt", 32'(c4), 32'd2);
        hold(1'b1, 5);
        tick(1'b1, 1'b1);
        chk("coll_rise", 32'(r4), 32'd1);
        chk("coll_cnt",  32'(c4), 32'd0);
        hold(1'b1, 2);
        hold(1'b0, 6);
        hold(1'b1, 6);
        chk("coll_next_cnt", 32'(c4), 32'd1);
        hold(1'b0, 6);

        // Asynchronous reset between edges with q_clean=1, rise_count=3.
        hold(1'b1, 6);
        hold(1'b0, 6);
        hold(1'b1, 8);
        chk("arst_pre_q",   32'(q4), 32'd1);
        chk("arst_pre_cnt", 32'(c4), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q",    32'(q4), 32'd0);
        chk("arst_rise", 32'(r4), 32'd0);
        chk("arst_fall", 32'(f4), 32'd0);
        chk("arst_cnt",  32'(c4), 32'd0);
        model_reset();
        @(negedge clk);
        hold(1'b1, 2);
        rst_n = 1'b1;
        tick(1'b1, 1'b0);
        chk("release_no_pulse", 32'(r4), 32'd0);
        hold(1'b1, 8);
        chk("release_requal_q", 32'(q4), 32'd1);

        // Randomized runs of varying length with sporadic clears and resets.
        cur_d = 1'b1;
        run_left = 0;
        for (int n = 0; n < 1500; n++) begin
            if (run_left == 0) begin
                cur_d    = 1'($urandom_range(0, 1));
                run_left = int'($urandom_range(1, 9));
            end
            run_left--;
            tick(cur_d, $urandom_range(0, 31) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 check_all();
                @(negedge clk);
                rst_n = 1'b1;
                check_all();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
